// File: rtl/parity_checker_serial.sv
// parity_checker_serial
//   Serial-frame parity checker. Receives LSB-first frames of DATA_W data bits
//   followed by one parity bit. Reports a per-frame parity result in even or
//   odd mode, and keeps error statistics for the link-status logic.
//
//   Build option: define PC_ERR_CNT_EN to implement the saturating error
//   counter. When it is undefined, err_cnt is tied to 0 and the counter logic
//   is removed; everything else is unchanged.
//
// Parameters
//   DATA_W  data bits per frame (>=1), excluding the parity bit
//   CNT_W   width of the saturating error counter
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-high reset
//   bit_valid    in   bit_in is valid this cycle
//   bit_in       in   serial bit
//   sof          in   start of frame (qualified by bit_valid), marks data bit 0
//   odd_mode     in   1 = odd parity, 0 = even parity; sampled at sof
//   clr_cnt      in   synchronous clear of err_cnt and err_sticky
//   done         out  1-cycle pulse: frame complete, data_out/par_err valid
//   data_out     out  assembled data word, held until next done
//   par_err      out  parity result of last frame, held until next done
//   frame_abort  out  1-cycle pulse: frame restarted before completion
//   err_sticky   out  set by any errored frame; cleared by clr_cnt or rst
//   err_cnt      out  saturating count of errored frames
module parity_checker_serial #(
  parameter int DATA_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              sof,
  input  logic              odd_mode,
  input  logic              clr_cnt,
  output logic              done,
  output logic [DATA_W-1:0] data_out,
  output logic              par_err,
  output logic              frame_abort,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                odd_q, odd_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                par_err_q, par_err_d;
  logic                abort_q, abort_d;
  logic                sticky_q, sticky_d;
  logic                err_event;

  // Frame FSM. Only cycles with bit_valid move anything, so arbitrary gaps
  // between bits are transparent.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    data_d     = data_q;
    odd_d      = odd_q;
    done_d     = 1'b0;
    data_out_d = data_out_q;
    par_err_d  = par_err_q;
    abort_d    = 1'b0;
    if (bit_valid) begin
      if (sof) begin
        // sof wins in every state: a frame in flight is dropped (abort pulse)
        // and this bit becomes data[0] of a fresh frame.
        abort_d   = (state_q != IDLE);
        data_d    = '0;
        data_d[0] = bit_in;
        odd_d     = odd_mode;
        idx_d     = IDX_W'(1);
        state_d   = (DATA_W == 1) ? PARITY : DATA;
      end else begin
        case (state_q)
          DATA: begin
            data_d[idx_q] = bit_in;
            if (idx_q == IDX_LAST) state_d = PARITY;
            else                   idx_d   = idx_q + IDX_W'(1);
          end
          PARITY: begin
            done_d     = 1'b1;
            data_out_d = data_q;
            par_err_d  = (^data_q) ^ bit_in ^ odd_q;
            state_d    = IDLE;
          end
          default: ; // IDLE: bits outside a frame are discarded
        endcase
      end
    end
  end

  // Statistics update on the same edge that raises done, so they are
  // consistent with par_err while done is high.
  assign err_event = done_d & par_err_d;

  always_comb begin
    sticky_d = sticky_q;
    if (clr_cnt)        sticky_d = 1'b0;
    else if (err_event) sticky_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      data_q     <= '0;
      odd_q      <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= '0;
      par_err_q  <= 1'b0;
      abort_q    <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      odd_q      <= odd_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
      par_err_q  <= par_err_d;
      abort_q    <= abort_d;
      sticky_q   <= sticky_d;
    end
  end

`ifdef PC_ERR_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // clr_cnt beats a same-cycle increment; saturate at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt)                        cnt_d = '0;
    else if (err_event && cnt_q != '1)  cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign err_cnt = cnt_q;
`else
  assign err_cnt = '0;
`endif

  assign done        = done_q;
  assign data_out    = data_out_q;
  assign par_err     = par_err_q;
  assign frame_abort = abort_q;
  assign err_sticky  = sticky_q;

endmodule

// File: tb/tb_parity_checker_serial.sv
module tb_parity_checker_serial;

  localparam int DW = 3;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          bit_valid, bit_in, sof, odd_mode, clr_cnt;
  logic          done, par_err, frame_abort, err_sticky;
  logic [DW-1:0] data_out;
  logic [CW-1:0] err_cnt;

  parity_checker_serial #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .sof(sof),
    .odd_mode(odd_mode), .clr_cnt(clr_cnt), .done(done), .data_out(data_out),
    .par_err(par_err), .frame_abort(frame_abort), .err_sticky(err_sticky),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          perr;
    logic          sticky;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef struct {
    logic          odd;
    logic [DW-1:0] data;
    logic          p;
    int            gap;
    logic          exp_err;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   abort_seen = 0;
  int   exp_abort = 0;

  // reference statistics
  logic          m_sticky = 1'b0;
  logic [CW-1:0] m_cnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic err, input logic clr);
    if (clr) begin
      m_sticky = 1'b0;
      m_cnt    = '0;
    end else if (err) begin
      m_sticky = 1'b1;
`ifdef PC_ERR_CNT_EN
      if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
`endif
    end
  endtask

  task automatic send_bit(input logic b, input logic s, input logic om, input logic c);
    @(negedge clk);
    bit_valid = 1'b1; bit_in = b; sof = s; odd_mode = om; clr_cnt = c;
    @(posedge clk);
  endtask

  // gap cycles: sof/bit_in/odd_mode carry junk that must be ignored
  task automatic idle(input int n, input logic c);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bit_valid = 1'b0; sof = 1'b1; bit_in = 1'($urandom); odd_mode = 1'($urandom);
      clr_cnt = c;
      @(posedge clk);
    end
  endtask

  task automatic send_frame(input logic odd, input logic [DW-1:0] d, input logic p,
                            input int gap, input logic exp_err, input logic clr);
    exp_t e;
    send_bit(d[0], 1'b1, odd, 1'b0);
    for (int i = 1; i < DW; i++) begin
      idle(gap > 0 ? int'($urandom_range(1, gap)) : 0, 1'b0);
      // odd_mode toggled mid-frame: only the sof sample may count
      send_bit(d[i], 1'b0, ~odd, 1'b0);
    end
    idle(gap > 0 ? int'($urandom_range(1, gap)) : 0, 1'b0);
    model_update(exp_err, clr);
    e.data = d; e.perr = exp_err; e.sticky = m_sticky; e.cnt = m_cnt;
    sb.push_back(e);
    send_bit(p, 1'b0, ~odd, clr);
    // hold clr through the done cycle as well
    if (clr) idle(1, 1'b1);
    idle(1, 1'b0);
  endtask

  // monitor: sample 1 time unit after each active edge
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (done && frame_abort) check("done_and_abort", 32'd1, 32'd0);
      if (frame_abort) abort_seen++;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("data_out", 32'(data_out), 32'(e.data));
          check("par_err", 32'(par_err), 32'(e.perr));
          check("err_sticky", 32'(err_sticky), 32'(e.sticky));
          check("err_cnt", 32'(err_cnt), 32'(e.cnt));
        end
      end
    end
  end

  vec_t tbl[8];

  initial begin
    tbl[0] = '{odd:1'b1, data:3'b101, p:1'b1, gap:0, exp_err:1'b0};
    tbl[1] = '{odd:1'b1, data:3'b101, p:1'b0, gap:0, exp_err:1'b1};
    tbl[2] = '{odd:1'b0, data:3'b011, p:1'b0, gap:0, exp_err:1'b0};
    tbl[3] = '{odd:1'b0, data:3'b110, p:1'b0, gap:5, exp_err:1'b0};
    tbl[4] = '{odd:1'b0, data:3'b111, p:1'b0, gap:0, exp_err:1'b1};
    tbl[5] = '{odd:1'b1, data:3'b000, p:1'b1, gap:2, exp_err:1'b0};
    tbl[6] = '{odd:1'b1, data:3'b000, p:1'b0, gap:0, exp_err:1'b1};
    tbl[7] = '{odd:1'b0, data:3'b001, p:1'b1, gap:3, exp_err:1'b0};

    rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; sof = 1'b0; odd_mode = 1'b0; clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_par_err", 32'(par_err), 32'd0);
    check("rst_abort", 32'(frame_abort), 32'd0);
    check("rst_sticky", 32'(err_sticky), 32'd0);
    check("rst_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk); rst = 1'b0;

    // bits outside a frame (no sof) must be discarded
    send_bit(1'b1, 1'b0, 1'b1, 1'b0);
    send_bit(1'b1, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b0);

    // table-driven frames
    for (int i = 0; i < 8; i++)
      send_frame(tbl[i].odd, tbl[i].data, tbl[i].p, tbl[i].gap, tbl[i].exp_err, 1'b0);
    idle(2, 1'b0);

    // restart after 2 data bits: abort, then odd 1,1,1 p=0 -> no error
    send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b1, 1'b0);
    exp_abort++;
    #1;
    check("abort_pulse", 32'(frame_abort), 32'd1);
    check("abort_no_done", 32'(done), 32'd0);
    send_bit(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("abort_one_cycle", 32'(frame_abort), 32'd0);
    send_bit(1'b1, 1'b0, 1'b0, 1'b0);
    begin
      exp_t e;
      e.data = 3'b111; e.perr = 1'b0; e.sticky = m_sticky; e.cnt = m_cnt;
      sb.push_back(e);
    end
    send_bit(1'b0, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);

    // explicit clear
    idle(1, 1'b1);
    model_update(1'b0, 1'b1);
    idle(1, 1'b0);
    #1;
    check("clr_cnt", 32'(err_cnt), 32'(m_cnt));
    check("clr_sticky", 32'(err_sticky), 32'(m_sticky));

    // saturation: five errored frames, then a sixth with clr_cnt alongside
    for (int i = 0; i < 5; i++) send_frame(1'b1, 3'b000, 1'b0, 0, 1'b1, 1'b0);
    idle(1, 1'b0);
    #1;
`ifdef PC_ERR_CNT_EN
    check("sat_cnt", 32'(err_cnt), 32'd3);
`else
    check("sat_cnt", 32'(err_cnt), 32'd0);
`endif
    send_frame(1'b1, 3'b000, 1'b0, 0, 1'b1, 1'b1);
    #1;
    check("clr_vs_inc_cnt", 32'(err_cnt), 32'd0);
    check("clr_vs_inc_sticky", 32'(err_sticky), 32'd0);

    // async reset mid-frame
    send_frame(1'b1, 3'b000, 1'b0, 0, 1'b1, 1'b0);
    idle(2, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    bit_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_data_out", 32'(data_out), 32'd0);
    check("arst_par_err", 32'(par_err), 32'd0);
    check("arst_sticky", 32'(err_sticky), 32'd0);
    check("arst_cnt", 32'(err_cnt), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_abort", 32'(frame_abort), 32'd0);
    model_update(1'b0, 1'b1);
    @(negedge clk); rst = 1'b0;
    // even 1,0,1 p=1 -> three ones -> error
    send_frame(1'b0, 3'b101, 1'b1, 1, 1'b1, 1'b0);
    send_frame(1'b1, 3'b110, 1'b1, 0, 1'b0, 1'b0);

    idle(4, 1'b0);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("abort_count", 32'(abort_seen), 32'(exp_abort));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
